// File: rtl/sbox_subbytes_pipe_pkg.sv
// Shared constants and GF(2^8) helpers for the pipelined AES S-box engine.
// The S-box is computed arithmetically (field inverse plus affine map) rather than stored as a table.
package sbox_subbytes_pipe_pkg;

    localparam int          SBOX_W      = 8;
    localparam logic [31:0] KAT_FWD_IN  = 32'h53020100;
    localparam logic [31:0] KAT_FWD_OUT = 32'hED777C63;

    localparam logic [7:0]  GF_POLY     = 8'h1B;
    localparam logic [7:0]  AFF_FWD_C   = 8'h63;
    localparam logic [7:0]  AFF_INV_C   = 8'h05;
    localparam logic [7:0]  INV_EXP     = 8'hFE;

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (SBOX_W - n));
    endfunction

    // Shift-and-add multiply, reducing by x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < SBOX_W; i++) begin
            p = p ^ (x & {SBOX_W{b[i]}});
            x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] e;
        r = 8'h01;
        e = INV_EXP;
        for (int i = SBOX_W - 1; i >= 0; i--) begin
            r = gf_mul(r, r);
            r = e[i] ? gf_mul(r, a) : r;
        end
        return r;
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] b);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ AFF_FWD_C;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] b);
        return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ AFF_INV_C;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return aff_fwd(gf_inv(b));
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return gf_inv(aff_inv(b));
    endfunction

endpackage

// File: rtl/sbox_subbytes_pipe_if.sv
// Valid/ready beat bus between the AES datapath and the S-box engine.
// The engine connects through the slave modport, its driver through master.
interface sbox_subbytes_pipe_if #(
    parameter int LANES = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_encrypt;
    logic [8*LANES-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*LANES-1:0]   out_data;

    modport master (
        output in_valid, in_encrypt, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_encrypt, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sbox_subbytes_pipe_lane.sv
// One byte lane of the S-box: forward substitution when encrypt=1, inverse otherwise.
// Purely combinational; the top level supplies all registers.
module sbox_lane
    import sbox_subbytes_pipe_pkg::*;
(
    input  logic              encrypt,
    input  logic [SBOX_W-1:0] byte_in,
    output logic [SBOX_W-1:0] byte_out
);

    // Pick the substitution direction for this byte.
    always_comb begin
        byte_out = '0;
        if (encrypt) begin
            byte_out = sbox_fwd(byte_in);
        end else begin
            byte_out = sbox_inv(byte_in);
        end
    end

endmodule

// File: rtl/sbox_subbytes_pipe.sv
// Pipelined multi-lane AES S-box engine with valid/ready flow control and bubble collapsing.
// Optional self-check of every emitted beat is enabled by `define SBOX_PIPE_FAULTCHK_EN.
module sbox_subbytes_pipe
    import sbox_subbytes_pipe_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    sbox_subbytes_pipe_if.slave   bus,
    output logic                  fault
);

    localparam int DW = SBOX_W * LANES;

    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] adv_s;
    logic [STAGES-1:0] pvalid_s;
    logic [DW-1:0]     data_r  [STAGES];
    logic [DW-1:0]     pdata_s [STAGES];
    logic              enc_r;
    logic [DW-1:0]     lane_out_s;

    // A stage advances when downstream drains or any stage from here to the output is empty.
    for (genvar k = 0; k < STAGES; k++) begin : g_src
        assign adv_s[k] = bus.out_ready | ~(&valid_r[STAGES-1:k]);
        if (k == 0) begin : g_in
            assign pvalid_s[k] = bus.in_valid;
            assign pdata_s[k]  = bus.in_data;
        end else if (k == 1) begin : g_sub
            assign pvalid_s[k] = valid_r[0];
            assign pdata_s[k]  = lane_out_s;
        end else begin : g_copy
            assign pvalid_s[k] = valid_r[k-1];
            assign pdata_s[k]  = data_r[k-1];
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sbox_lane u_lane (
            .encrypt  (enc_r),
            .byte_in  (data_r[0][SBOX_W*i +: SBOX_W]),
            .byte_out (lane_out_s[SBOX_W*i +: SBOX_W])
        );
    end

    // Stage registers; data only loads with a valid beat so idle inputs never disturb state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            enc_r   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                data_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv_s[k]) begin
                    valid_r[k] <= pvalid_s[k];
                    if (pvalid_s[k]) begin
                        data_r[k] <= pdata_s[k];
                    end
                end
            end
            if (adv_s[0] && bus.in_valid) begin
                enc_r <= bus.in_encrypt;
            end
        end
    end

    assign bus.in_ready  = adv_s[0];
    assign bus.out_valid = valid_r[STAGES-1];

    // With one stage the substitution follows the register, so mask it to keep idle output at zero.
    if (STAGES == 1) begin : g_out_comb
        assign bus.out_data = valid_r[0] ? lane_out_s : '0;
    end else begin : g_out_reg
        assign bus.out_data = data_r[STAGES-1];
    end

`ifdef SBOX_PIPE_FAULTCHK_EN
    logic [DW-1:0] chk_s;
    logic [DW-1:0] ref_orig_s;
    logic          ref_enc_s;
    logic          fault_r;

    // Stage 1 still holds untransformed bytes, so only later stages need shadow copies.
    if (STAGES == 1) begin : g_ref_direct
        assign ref_orig_s = data_r[0];
        assign ref_enc_s  = enc_r;
    end else begin : g_ref_shadow
        logic [DW-1:0]     orig_r  [1:STAGES-1];
        logic [DW-1:0]     porig_s [1:STAGES-1];
        logic [STAGES-1:1] senc_r;
        logic [STAGES-1:1] penc_s;

        for (genvar k = 1; k < STAGES; k++) begin : g_sh_src
            if (k == 1) begin : g_first
                assign porig_s[k] = data_r[0];
                assign penc_s[k]  = enc_r;
            end else begin : g_next
                assign porig_s[k] = orig_r[k-1];
                assign penc_s[k]  = senc_r[k-1];
            end
        end

        // Shadow bytes and mode move in lockstep with the main stage registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                senc_r <= '0;
                for (int k = 1; k < STAGES; k++) begin
                    orig_r[k] <= '0;
                end
            end else begin
                for (int k = 1; k < STAGES; k++) begin
                    if (adv_s[k] && pvalid_s[k]) begin
                        orig_r[k] <= porig_s[k];
                        senc_r[k] <= penc_s[k];
                    end
                end
            end
        end

        assign ref_orig_s = orig_r[STAGES-1];
        assign ref_enc_s  = senc_r[STAGES-1];
    end

    for (genvar i = 0; i < LANES; i++) begin : g_chk
        sbox_lane u_chk (
            .encrypt  (~ref_enc_s),
            .byte_in  (bus.out_data[SBOX_W*i +: SBOX_W]),
            .byte_out (chk_s[SBOX_W*i +: SBOX_W])
        );
    end

    // Sticky mismatch flag, evaluated only on an actual output transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else if (bus.out_valid && bus.out_ready && (chk_s != ref_orig_s)) begin
            fault_r <= 1'b1;
        end else begin
            fault_r <= fault_r;
        end
    end

    assign fault = fault_r;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_sbox_subbytes_pipe.sv
// Scoreboard bench for sbox_subbytes_pipe: a driver pushes expected beats on accept,
// a monitor pops and compares on every output transfer.
module tb_sbox_subbytes_pipe;
    import sbox_subbytes_pipe_pkg::*;

    localparam int LANES  = 4;
    localparam int STAGES = 2;

    typedef struct {
        logic [31:0] data;
        int          acc_cyc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic fault;
    logic ready_hold;
    logic rnd_en;
    logic rnd_bit = 1'b1;
    logic lat_en;
    logic ovr_en;
    logic [31:0] ovr_val;
    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];
    exp_t sb_q [$];
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int n_in = 0;
    int n_out = 0;
    int n_drop = 0;
    logic exp_fault;

    sbox_subbytes_pipe_if #(.LANES(LANES)) bus ();

    sbox_subbytes_pipe #(.LANES(LANES), .STAGES(STAGES)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .fault (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    assign bus.out_ready = rnd_en ? rnd_bit : ready_hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rl(input logic [7:0] v, input int n);
        logic [7:0] a;
        logic [7:0] b;
        a = v << n;
        b = v >> (8 - n);
        return a | b;
    endfunction

    // Standard generator walk: p steps through powers of 3, q through powers of 1/3.
    task automatic build_tables();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1B : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            fwd_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        fwd_t[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input logic e);
        logic [31:0] r;
        logic [7:0]  b;
        r = 32'h0;
        for (int i = 0; i < LANES; i++) begin
            b = d[8*i +: 8];
            r[8*i +: 8] = e ? fwd_t[b] : inv_t[b];
        end
        return r;
    endfunction

    // Accept tracker: every input transfer produces one expected output.
    always @(negedge clk) begin
        exp_t it;
        if (!rst && bus.in_valid && bus.in_ready) begin
            it.data    = ovr_en ? ovr_val : model(bus.in_data, bus.in_encrypt);
            it.acc_cyc = cyc;
            it.lat     = lat_en;
            sb_q.push_back(it);
            n_in++;
        end
    end

    // Monitor: pop on transfer, check hold value while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got %h expected no beat", bus.out_data);
            end else if (bus.out_ready) begin
                e = sb_q.pop_front();
                n_out++;
                chk("out_data", bus.out_data, e.data);
                if (e.lat) chk("latency", 32'(cyc - e.acc_cyc), 32'(STAGES));
            end else begin
                chk("hold_data", bus.out_data, sb_q[0].data);
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic e);
        int  n;
        logic acc;
        n = 0;
        acc = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_data    = d;
        bus.in_encrypt = e;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            n++;
            @(posedge clk);
            #1;
        end
        bus.in_valid   = 1'b0;
        bus.in_data    = $urandom;
        bus.in_encrypt = 1'($urandom_range(0, 1));
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_exp(input logic [31:0] d, input logic e, input logic [31:0] x);
        ovr_en  = 1'b1;
        ovr_val = x;
        send(d, e);
        ovr_en  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] bp_d [8];
        logic        bp_e [8];
        logic [7:0]  v;
        int          idx;
        int          n;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_encrypt = 1'b0;
        bus.in_data = 32'h0;
        ready_hold = 1'b1;
        rnd_en = 1'b0;
        lat_en = 1'b1;
        ovr_en = 1'b0;
        ovr_val = 32'h0;
`ifdef SBOX_PIPE_FAULTCHK_EN
        exp_fault = 1'b1;
`else
        exp_fault = 1'b0;
`endif
        build_tables();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Known-answer beats and alternating modes on consecutive beats.
        send_exp(KAT_FWD_IN, 1'b1, KAT_FWD_OUT);
        send_exp(KAT_FWD_OUT, 1'b0, KAT_FWD_IN);
        send_exp(32'h00000000, 1'b1, 32'h63636363);
        send_exp(32'h00000000, 1'b0, 32'h52525252);
        send_exp(32'h00000000, 1'b1, 32'h63636363);
        send_exp(32'h00000000, 1'b0, 32'h52525252);
        drain();

        // Every byte value in every lane, forward then inverse.
        for (int m = 1; m >= 0; m--) begin
            for (int i = 0; i < 256; i++) begin
                v = 8'(i);
                send({v + 8'd192, v + 8'd128, v + 8'd64, v}, 1'(m));
            end
        end
        drain();

        // Random beats with random back-pressure and input gaps.
        lat_en = 1'b0;
        rnd_en = 1'b1;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send($urandom, 1'($urandom_range(0, 1)));
        end
        rnd_en = 1'b0;
        ready_hold = 1'b1;
        drain();

        // Back-pressure: only STAGES beats fit while the output is stalled.
        for (int i = 0; i < 8; i++) begin
            bp_d[i] = $urandom;
            bp_e[i] = 1'($urandom_range(0, 1));
        end
        ready_hold = 1'b0;
        idx = 0;
        bus.in_valid = 1'b1;
        bus.in_data = bp_d[0];
        bus.in_encrypt = bp_e[0];
        repeat (6) begin
            @(negedge clk);
            if (bus.in_ready) idx++;
            @(posedge clk);
            #1;
            if (idx < 8) begin
                bus.in_data = bp_d[idx];
                bus.in_encrypt = bp_e[idx];
            end
        end
        chk("bp_accepted", 32'(idx), 32'(STAGES));
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        ready_hold = 1'b1;
        n = 0;
        while (idx < 8 && n < 100) begin
            @(negedge clk);
            if (bus.in_ready) idx++;
            @(posedge clk);
            #1;
            if (idx < 8) begin
                bus.in_data = bp_d[idx];
                bus.in_encrypt = bp_e[idx];
            end
            n++;
        end
        bus.in_valid = 1'b0;
        chk("bp_all_accepted", 32'(idx), 32'd8);
        drain();

        // Corrupt the substitution result of one beat.
        lat_en = 1'b1;
        chk("fault_clean", 32'(fault), 32'd0);
        force dut.lane_out_s = 32'hDEADBEEF;
        send_exp(32'h00000000, 1'b1, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        release dut.lane_out_s;
        drain();
        chk("fault_set", 32'(fault), 32'(exp_fault));
        repeat (5) @(posedge clk);
        #1;
        chk("fault_sticky", 32'(fault), 32'(exp_fault));

        // Reset with two beats in flight.
        send($urandom, 1'b1);
        send($urandom, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        n_drop += sb_q.size();
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_fault", 32'(fault), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        send_exp(32'h01010101, 1'b1, 32'h7C7C7C7C);
        drain();

        chk("beat_count", 32'(n_out + n_drop), 32'(n_in));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
